// File: rtl/pulp_obi_limiter.sv
// OBI outstanding-transaction limiter.
// Passes the request/response channels straight through and gates mem_req_o so that no more
// than MAX_OUTSTANDING granted-but-unanswered transactions are ever in flight. A drain request
// blocks new traffic until every outstanding response has come back.
module pulp_obi_limiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          RVALID_BYPASS   = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    // core side
    input  logic                                     core_req_i,
    input  logic [ADDR_WIDTH-1:0]                    core_addr_i,
    input  logic                                     core_we_i,
    input  logic [DATA_WIDTH/8-1:0]                  core_be_i,
    input  logic [DATA_WIDTH-1:0]                    core_wdata_i,
    output logic                                     core_gnt_o,
    output logic                                     core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    core_rdata_o,
    // memory side
    output logic                                     mem_req_o,
    output logic [ADDR_WIDTH-1:0]                    mem_addr_o,
    output logic                                     mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                  mem_be_o,
    output logic [DATA_WIDTH-1:0]                    mem_wdata_o,
    input  logic                                     mem_gnt_i,
    input  logic                                     mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata_i,
    // control / status
    input  logic                                     drain_i,
    output logic                                     drained_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StRun, StDrain, StDrained} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          allow;
    logic          accept;

    // Payload and response pass through untouched.
    assign mem_addr_o    = core_addr_i;
    assign mem_we_o      = core_we_i;
    assign mem_be_o      = core_be_i;
    assign mem_wdata_o   = core_wdata_i;
    assign core_rvalid_o = mem_rvalid_i;
    assign core_rdata_o  = mem_rdata_i;

    assign accept        = mem_req_o & mem_gnt_i;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

    // Outstanding counter; saturates at both ends so stray grants/responses cannot wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !mem_rvalid_i) begin
            if (cnt_q != MaxCnt) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (mem_rvalid_i && !accept) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // A response with nothing in flight is a protocol violation; the flag is sticky.
    always_comb begin
        err_d = err_q;
        if (mem_rvalid_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // Counter and error flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; decisions use the post-update count.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (drain_i) begin
                    state_d = (cnt_d == '0) ? StDrained : StDrain;
                end
            end
            StDrain: begin
                // Withdrawing the drain request wins over completion in the same cycle.
                if (!drain_i) begin
                    state_d = StRun;
                end else if (cnt_d == '0) begin
                    state_d = StDrained;
                end
            end
            StDrained: begin
                if (!drain_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs: request gating, grant and drain status.
    always_comb begin
        allow = 1'b0;
        if (state_q == StRun) begin
            if (cnt_q < MaxCnt) begin
                allow = 1'b1;
            end else if (RVALID_BYPASS && (cnt_q == MaxCnt) && mem_rvalid_i) begin
                // A slot retires this cycle, so the new request can reuse it.
                allow = 1'b1;
            end
        end
        mem_req_o  = core_req_i & allow;
        core_gnt_o = mem_req_o & mem_gnt_i;
        drained_o  = (state_q == StDrained);
    end

endmodule
